// File: rtl/branch_predictor_if.sv
// Branch predictor bus: groups the fetch-stage lookup, the execute-stage
// resolution/update, and the statistics counters.
//   master : pipeline side (drives pc_f and upd_*, observes predictions,
//            mispredict/redirect and counters)
//   slave  : predictor side (branch_predictor)
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;
    logic            upd_valid_e;
    logic [XLEN-1:0] upd_pc_e;
    logic            upd_taken_e;
    logic [XLEN-1:0] upd_target_e;
    logic            upd_pred_taken_e;
    logic [XLEN-1:0] upd_pred_target_e;
    logic            mispredict_e;
    logic [XLEN-1:0] redirect_pc_e;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output pc_f, upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
               upd_pred_taken_e, upd_pred_target_e,
        input  pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e,
               branch_count, mispredict_count
    );

    modport slave (
        input  pc_f, upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
               upd_pred_taken_e, upd_pred_target_e,
        output pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
//   clk   : single clock, all state changes on rising edge
//   rst_n : asynchronous active-low reset (clears valid bits, counters -> 01,
//           statistics -> 0)
//   bus   : branch_predictor_if.slave
//           fetch   : pc_f -> pred_taken_f / pred_target_f (zero-cycle lookup)
//           execute : upd_* resolve a branch, producing mispredict_e and
//                     redirect_pc_e combinationally and updating the table
//           stats   : branch_count / mispredict_count (saturating)
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];
    logic [1:0]         ctrs    [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_e;
    logic             hit_f;
    logic             hit_e;
    logic             alloc_e;
    logic             mispredict;

    always_comb begin
        idx_f   = bus.pc_f[IDX_W+1:2];
        tag_f   = bus.pc_f[XLEN-1:IDX_W+2];
        idx_e   = bus.upd_pc_e[IDX_W+1:2];
        tag_e   = bus.upd_pc_e[XLEN-1:IDX_W+2];
        hit_f   = valid[idx_f] && (tags[idx_f] == tag_f);
        hit_e   = valid[idx_e] && (tags[idx_e] == tag_e);
        alloc_e = bus.upd_valid_e && !hit_e && bus.upd_taken_e;
    end

    // Lookup reads current (pre-update) state, so a same-cycle update to
    // the same index only becomes visible after the edge.
    always_comb begin
        bus.pred_taken_f  = hit_f && ctrs[idx_f][1];
        bus.pred_target_f = bus.pred_taken_f ? targets[idx_f]
                                             : bus.pc_f + XLEN'(4);
    end

    always_comb begin
        mispredict = bus.upd_valid_e &&
                     ((bus.upd_taken_e != bus.upd_pred_taken_e) ||
                      (bus.upd_taken_e && bus.upd_pred_taken_e &&
                       (bus.upd_target_e != bus.upd_pred_target_e)));
        bus.mispredict_e  = mispredict;
        bus.redirect_pc_e = bus.upd_taken_e ? bus.upd_target_e
                                            : bus.upd_pc_e + XLEN'(4);
    end

    // Valid bits and counters: reset-controlled state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctrs[i[IDX_W-1:0]] <= 2'b01;
            end
        end else if (bus.upd_valid_e) begin
            if (hit_e) begin
                if (bus.upd_taken_e) begin
                    if (ctrs[idx_e] != 2'b11) ctrs[idx_e] <= ctrs[idx_e] + 2'd1;
                end else begin
                    if (ctrs[idx_e] != 2'b00) ctrs[idx_e] <= ctrs[idx_e] - 2'd1;
                end
            end else if (bus.upd_taken_e) begin
                valid[idx_e] <= 1'b1;
                ctrs[idx_e]  <= 2'b10;
            end
        end
    end

    // Tag/target storage has no reset: it is only observable through a set
    // valid bit, and any write made while in reset stays hidden.
    always_ff @(posedge clk) begin
        if (alloc_e) begin
            tags[idx_e]    <= tag_e;
            targets[idx_e] <= bus.upd_target_e;
        end else if (bus.upd_valid_e && hit_e && bus.upd_taken_e) begin
            targets[idx_e] <= bus.upd_target_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            if (bus.upd_valid_e && (bus.branch_count != '1))
                bus.branch_count <= bus.branch_count + 32'd1;
            if (mispredict && (bus.mispredict_count != '1))
                bus.mispredict_count <= bus.mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int ENT  = 16;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;

    branch_predictor_if #(.XLEN(XLEN)) bus ();

    branch_predictor #(.ENTRIES(ENT), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a table keyed by index holding (valid, tag, target,
    // confidence 0..3), with index/tag derived by integer arithmetic.
    int          m_valid [ENT];
    longint      m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_conf  [ENT];
    longint      m_bc;
    longint      m_mc;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((longint'(pc) / 4) % ENT);
    endfunction

    function automatic longint m_tg(input logic [31:0] pc);
        return longint'(pc) / (4 * ENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] != 0 && m_tag[m_idx(pc)] == m_tg(pc);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_conf[i]  = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        t   = m_hit(pc) && m_conf[m_idx(pc)] >= 2;
        tgt = t ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endtask

    task automatic m_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int i;
        i = m_idx(pc);
        if (m_hit(pc)) begin
            if (taken) begin
                m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
                m_tgt[i]  = tgt;
            end else begin
                m_conf[i] = (m_conf[i] > 0) ? m_conf[i] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[i] = 1;
            m_tag[i]   = m_tg(pc);
            m_tgt[i]   = tgt;
            m_conf[i]  = 2;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs before the
    // edge, advance model at the edge, check counters after it.
    task automatic step(input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic upt,
                        input logic [31:0] uptgt, input logic [31:0] fpc);
        logic        et;
        logic [31:0] etg;
        logic        em;
        bus.upd_valid_e       = uv;
        bus.upd_pc_e          = upc;
        bus.upd_taken_e       = ut;
        bus.upd_target_e      = utgt;
        bus.upd_pred_taken_e  = upt;
        bus.upd_pred_target_e = uptgt;
        bus.pc_f              = fpc;
        #1;
        m_predict(fpc, et, etg);
        chk("pred_taken", 64'(bus.pred_taken_f), 64'(et));
        chk("pred_target", 64'(bus.pred_target_f), 64'(etg));
        em = uv && ((ut != upt) || (ut && upt && utgt != uptgt));
        chk("mispredict", 64'(bus.mispredict_e), 64'(em));
        if (em) chk("redirect", 64'(bus.redirect_pc_e), 64'(ut ? utgt : upc + 32'd4));
        @(posedge clk);
        if (uv) begin
            m_update(upc, ut, utgt);
            m_bc++;
            if (em) m_mc++;
        end
        #1;
        chk("branch_count", 64'(bus.branch_count), 64'(m_bc));
        chk("mispredict_count", 64'(bus.mispredict_count), 64'(m_mc));
        @(negedge clk);
    endtask

    logic        rt;
    logic [31:0] rtg, rpc, rfpc, rtarget, rptgt;
    logic        rtaken, rpt;

    initial begin
        rst_n = 1'b0;
        bus.pc_f = 32'h100;
        bus.upd_valid_e = 1'b0;
        bus.upd_pc_e = '0;
        bus.upd_taken_e = 1'b0;
        bus.upd_target_e = '0;
        bus.upd_pred_taken_e = 1'b0;
        bus.upd_pred_target_e = '0;
        m_reset();
        #1;
        chk("rst_pred_taken", 64'(bus.pred_taken_f), 64'd0);
        chk("rst_pred_target", 64'(bus.pred_target_f), 64'h104);
        chk("rst_bcount", 64'(bus.branch_count), 64'd0);
        chk("rst_mcount", 64'(bus.mispredict_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold miss
        step(0, 0, 0, 0, 0, 0, 32'h100);
        // Allocate 0x100 -> 0x200
        step(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        chk("alloc_target_const", 64'(bus.pred_target_f), 64'h200);
        chk("alloc_mcount_const", 64'(bus.mispredict_count), 64'd1);
        // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10 -> 01 -> 00 -> 00
        step(1, 32'h100, 0, 32'h104, 1, 32'h200, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        step(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100);
        step(1, 32'h100, 1, 32'h200, 1, 32'h200, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        repeat (4) step(1, 32'h100, 0, 32'h104, 0, 32'h104, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        // Raise back to taken, then target change with same-cycle lookup
        step(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100);
        step(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100);
        step(1, 32'h100, 1, 32'h300, 1, 32'h200, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        chk("new_target_const", 64'(bus.pred_target_f), 64'h300);
        // Aliasing: 0x140 shares index with 0x100
        step(1, 32'h140, 1, 32'h400, 0, 32'h144, 32'h140);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h140);
        chk("alias_hit_const", 64'(bus.pred_taken_f), 64'd1);

        // Randomized traffic over a small PC pool so aliasing is common
        for (int n = 0; n < 400; n++) begin
            rpc     = ($urandom_range(0, 127) << 2) | 32'($urandom_range(0, 3));
            rfpc    = ($urandom_range(0, 3) == 0) ? rpc
                    : (($urandom_range(0, 127) << 2) | 32'($urandom_range(0, 3)));
            rtaken  = 1'($urandom_range(0, 1));
            rtarget = $urandom_range(0, 7) << 8;
            if ($urandom_range(0, 9) < 7) begin
                m_predict(rpc, rpt, rptgt);
            end else begin
                rpt   = 1'($urandom_range(0, 1));
                rptgt = $urandom_range(0, 7) << 8;
            end
            step(1'($urandom_range(0, 3) != 0), rpc, rtaken, rtarget, rpt, rptgt, rfpc);
        end

        // Reset asserted between edges while an update is pending
        step(1, 32'h180, 1, 32'h500, 0, 32'h184, 32'h180);
        bus.upd_valid_e  = 1'b1;
        bus.upd_pc_e     = 32'h100;
        bus.upd_taken_e  = 1'b1;
        bus.upd_target_e = 32'h600;
        bus.pc_f         = 32'h180;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("midrst_pred_taken", 64'(bus.pred_taken_f), 64'd0);
        chk("midrst_pred_target", 64'(bus.pred_target_f), 64'h184);
        chk("midrst_bcount", 64'(bus.branch_count), 64'd0);
        chk("midrst_mcount", 64'(bus.mispredict_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h180);
        step(1, 32'h200, 0, 32'h0, 0, 32'h204, 32'h200);
        step(0, 0, 0, 0, 0, 0, 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of table entries (power of two, 4..256).
REQ-002 SHALL have parameter XLEN, default 32, PC and target width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc_f  input  XLEN  fetch-stage PC to predict.
REQ-006 SHALL have port pred_taken_f  output  1  prediction: branch at pc_f taken.
REQ-007 SHALL have port pred_target_f  output  XLEN  predicted next PC for pc_f.
REQ-008 SHALL have port upd_valid_e  input  1  a conditional branch resolves in execute this cycle.
REQ-009 SHALL have port upd_pc_e  input  XLEN  PC of the resolving branch.
REQ-010 SHALL have port upd_taken_e  input  1  actual outcome, driven by the branch-taken generator.
REQ-011 SHALL have port upd_target_e  input  XLEN  actual branch target computed in execute.
REQ-012 SHALL have port upd_pred_taken_e  input  1  prediction carried down the pipe for this branch.
REQ-013 SHALL have port upd_pred_target_e  input  XLEN  predicted target carried down the pipe.
REQ-014 SHALL have port mispredict_e  output  1  flush request for fetch/decode.
REQ-015 SHALL have port redirect_pc_e  output  XLEN  correct next PC when mispredict_e is 1.
REQ-016 SHALL have port branch_count  output  32  resolved-branch count.
REQ-017 SHALL have port mispredict_count  output  32  mispredict count.

Function
REQ-018 SHALL hold ENTRIES entries, each: valid bit, tag, XLEN-bit target, 2-bit saturating counter.
REQ-019 SHALL index with pc[log2(ENTRIES)+1:2] and tag with pc[XLEN-1:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-020 SHALL define hit = valid & tag match at the indexed entry.
REQ-021 SHALL drive pred_taken_f = hit & counter[1], combinationally from pc_f and current table state (zero-cycle lookup).
REQ-022 SHALL drive pred_target_f = stored target when pred_taken_f is 1, else pc_f + 4 (modulo 2^XLEN).
REQ-023 SHALL, on a clock edge with upd_valid_e = 1 and hit on upd_pc_e: increment counter if upd_taken_e (saturate at 2'b11), else decrement (saturate at 2'b00).
REQ-024 SHALL, on an updating hit with upd_taken_e = 1, overwrite the stored target with upd_target_e.
REQ-025 SHALL, on upd_valid_e = 1, miss, upd_taken_e = 1: allocate the indexed entry (valid=1, new tag, target=upd_target_e, counter=2'b10), replacing any prior occupant.
REQ-026 SHALL, on miss with upd_taken_e = 0, leave the table unchanged.
REQ-027 SHALL leave table and counters unchanged when upd_valid_e = 0.
REQ-028 SHALL drive mispredict_e = upd_valid_e & ((upd_taken_e != upd_pred_taken_e) | (upd_taken_e & upd_pred_taken_e & upd_target_e != upd_pred_target_e)), combinationally, same cycle.
REQ-029 SHALL drive redirect_pc_e = upd_target_e if upd_taken_e, else upd_pc_e + 4; value is don't-care when mispredict_e = 0.
REQ-030 SHALL, when lookup and update hit the same index in one cycle, return pre-update contents to pc_f; new contents visible from the next cycle.
REQ-031 SHALL increment branch_count on each clock edge with upd_valid_e = 1, and mispredict_count when mispredict_e = 1; both saturate at 32'hFFFF_FFFF.

Reset
REQ-032 SHALL, while rst_n = 0, asynchronously clear all valid bits, set all counters to 2'b01, and clear branch_count and mispredict_count.
REQ-033 SHALL output pred_taken_f = 0, pred_target_f = pc_f + 4 during and after reset until a taken update allocates.
REQ-034 SHALL discard an update coinciding with reset assertion; reset deassertion mid-stream resumes with empty table.

Verification
REQ-035 Cold miss: after reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104; counts 0.
REQ-036 Allocate: update pc=0x100, taken=1, target=0x200, pred_taken=0 -> mispredict_e=1, redirect_pc_e=0x200; next cycle pc_f=0x100 -> pred_taken_f=1, target 0x200; mispredict_count=1.
REQ-037 Hysteresis: from counter 2'b10 at 0x100, one not-taken update -> counter 01, pred_taken_f=0; two taken updates -> 11; three not-taken -> 00, fourth stays 00.
REQ-038 Aliasing (ENTRIES=16): 0x100 allocated, taken update at 0x140 (same index, new tag) evicts it -> pc_f=0x100 misses, 0x140 hits.
REQ-039 Target change/bypass: hit at 0x100, taken, upd_target 0x300, pred_target 0x200 -> mispredict_e=1, redirect 0x300; same-cycle lookup of 0x100 still returns 0x200, next cycle 0x300.
REQ-040 Reset mid-run: assert rst_n=0 asynchronously between edges after allocations -> outputs immediately revert to REQ-033 values, counts 0.
